// File: rtl/tile_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tile_fetch_ctrl_pkg
//  Brief    : Shared state encoding and fetch constants for tile_fetch_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
package tile_fetch_ctrl_pkg;

    localparam int FETCH_LEN = 13;
    localparam int DRAIN_LEN = 2;
    localparam int K_W       = $clog2(FETCH_LEN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    // One line-buffer word packs four pixels.
    function automatic int word_w(input int dw);
        return dw * 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_pos_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : tile_pos_cnt
//  Brief    : Tile row/column position counters with wrap and last-tile flag.
//  Revision : 1.0  initial release
// ============================================================================
module tile_pos_cnt #(
    parameter int ROW_CNT_WIDTH = 4,
    parameter int COL_CNT_WIDTH = 5,
    parameter int NUM_TILE_ROWS = 8,
    parameter int NUM_TILE_COLS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
    output logic [ROW_CNT_WIDTH-1:0] row_cnt,
    output logic [COL_CNT_WIDTH-1:0] col_cnt,
    output logic [COL_CNT_WIDTH-1:0] next_col,
    output logic                     last_tile
);

    localparam logic [ROW_CNT_WIDTH-1:0] c_last_row = ROW_CNT_WIDTH'(NUM_TILE_ROWS - 1);
    localparam logic [COL_CNT_WIDTH-1:0] c_last_col = COL_CNT_WIDTH'(NUM_TILE_COLS - 1);

    logic                     w_col_last;
    logic                     w_row_last;
    logic [ROW_CNT_WIDTH-1:0] w_next_row;

    assign w_col_last = (col_cnt == c_last_col);
    assign w_row_last = (row_cnt == c_last_row);
    assign last_tile  = w_col_last & w_row_last;

    // Advancing past the last tile wraps both counters back to the origin.
    assign next_col   = w_col_last ? '0 : col_cnt + COL_CNT_WIDTH'(1);
    assign w_next_row = !w_col_last ? row_cnt :
                        (w_row_last ? '0 : row_cnt + ROW_CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (advance) begin
            row_cnt <= w_next_row;
            col_cnt <= next_col;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tile_fetch_ctrl
//  Brief    : Walks the frame tile by tile, fetching 13 line-buffer words per
//             tile and handing them to the tile array loader.
//  Revision : 1.0  initial release
// ============================================================================
module tile_fetch_ctrl
    import tile_fetch_ctrl_pkg::*;
#(
    parameter int DW_IN         = 10,
    parameter int ROW_CNT_WIDTH = 4,
    parameter int COL_CNT_WIDTH = 5,
    parameter int ADDR_W        = 9,
    parameter int NUM_TILE_ROWS = 8,
    parameter int NUM_TILE_COLS = 16,
    parameter int TILE_STRIDE   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       tile_ack,
    output logic                       rd_en,
    output logic [ROW_CNT_WIDTH-1:0]   rd_row,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [word_w(DW_IN)-1:0]   rd_data1,
    input  logic [word_w(DW_IN)-1:0]   rd_data2,
    input  logic [word_w(DW_IN)-1:0]   rd_data3,
    input  logic [word_w(DW_IN)-1:0]   rd_data4,
    input  logic [word_w(DW_IN)-1:0]   rd_data5,
    input  logic [word_w(DW_IN)-1:0]   rd_data6,
    input  logic [word_w(DW_IN)-1:0]   rd_data7,
    output logic [word_w(DW_IN)-1:0]   data_out1,
    output logic [word_w(DW_IN)-1:0]   data_out2,
    output logic [word_w(DW_IN)-1:0]   data_out3,
    output logic [word_w(DW_IN)-1:0]   data_out4,
    output logic [word_w(DW_IN)-1:0]   data_out5,
    output logic [word_w(DW_IN)-1:0]   data_out6,
    output logic [word_w(DW_IN)-1:0]   data_out7,
    output logic                       array_load_start,
    output logic [ROW_CNT_WIDTH-1:0]   row_cnt,
    output logic [COL_CNT_WIDTH-1:0]   col_cnt,
    output logic                       busy,
    output logic                       frame_done
);

    localparam logic [K_W-1:0] c_last_k     = K_W'(FETCH_LEN - 1);
    localparam logic [K_W-1:0] c_last_drain = K_W'(DRAIN_LEN - 1);

    state_t                   r_state;
    logic [K_W-1:0]           r_k;
    logic                     r_rd_en_d1;
    logic                     r_rd_en_d2;

    logic                     w_start;
    logic                     w_advance;
    logic                     w_last_tile;
    logic [COL_CNT_WIDTH-1:0] w_next_col;
    logic [COL_CNT_WIDTH-1:0] w_issue_col;
    logic [ADDR_W-1:0]        w_base;

    assign w_start     = (r_state == S_IDLE) && frame_start;
    assign w_advance   = (r_state == S_WAIT_ACK) && tile_ack;
    assign w_issue_col = w_start ? '0 : w_next_col;
    assign w_base      = ADDR_W'(32'(w_issue_col) * 32'(TILE_STRIDE));
    assign rd_row      = row_cnt;

    tile_pos_cnt #(
        .ROW_CNT_WIDTH (ROW_CNT_WIDTH),
        .COL_CNT_WIDTH (COL_CNT_WIDTH),
        .NUM_TILE_ROWS (NUM_TILE_ROWS),
        .NUM_TILE_COLS (NUM_TILE_COLS)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start),
        .advance   (w_advance),
        .row_cnt   (row_cnt),
        .col_cnt   (col_cnt),
        .next_col  (w_next_col),
        .last_tile (w_last_tile)
    );

    // The address register simply increments, so wrap past 2^ADDR_W falls out naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_state <= S_ISSUE;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= w_base;
                        r_k     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_k == c_last_k) begin
                        r_state <= S_DRAIN;
                        rd_en   <= 1'b0;
                        r_k     <= '0;
                    end else begin
                        r_k     <= r_k + K_W'(1);
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_k == c_last_drain) begin
                        r_state <= S_WAIT_ACK;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (tile_ack) begin
                        if (w_last_tile) begin
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            rd_en   <= 1'b1;
                            rd_addr <= w_base;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Words arrive one cycle after rd_en and are re-registered before the loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en_d1       <= 1'b0;
            r_rd_en_d2       <= 1'b0;
            array_load_start <= 1'b0;
            data_out1        <= '0;
            data_out2        <= '0;
            data_out3        <= '0;
            data_out4        <= '0;
            data_out5        <= '0;
            data_out6        <= '0;
            data_out7        <= '0;
        end else begin
            r_rd_en_d1       <= rd_en;
            r_rd_en_d2       <= r_rd_en_d1;
            array_load_start <= r_rd_en_d1 & ~r_rd_en_d2;
            if (r_rd_en_d1) begin
                data_out1 <= rd_data1;
                data_out2 <= rd_data2;
                data_out3 <= rd_data3;
                data_out4 <= rd_data4;
                data_out5 <= rd_data5;
                data_out6 <= rd_data6;
                data_out7 <= rd_data7;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_fetch_ctrl
//  Brief    : Self-checking bench for tile_fetch_ctrl (3x4 tiles, 5-bit addr).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_fetch_ctrl;

    localparam int WW     = 40;
    localparam int ROWS   = 3;
    localparam int COLS   = 4;
    localparam int STRIDE = 7;
    localparam int AW     = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           frame_start = 1'b0;
    logic           tile_ack = 1'b0;
    logic           rd_en;
    logic [3:0]     rd_row;
    logic [AW-1:0]  rd_addr;
    logic [WW-1:0]  lb   [1:7];
    logic [WW-1:0]  dout [1:7];
    logic           array_load_start;
    logic [3:0]     row_cnt;
    logic [4:0]     col_cnt;
    logic           busy;
    logic           frame_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int exp_row = 0;
    int exp_col = 0;

    tile_fetch_ctrl #(
        .DW_IN(10), .ROW_CNT_WIDTH(4), .COL_CNT_WIDTH(5), .ADDR_W(AW),
        .NUM_TILE_ROWS(ROWS), .NUM_TILE_COLS(COLS), .TILE_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .tile_ack(tile_ack),
        .rd_en(rd_en), .rd_row(rd_row), .rd_addr(rd_addr),
        .rd_data1(lb[1]), .rd_data2(lb[2]), .rd_data3(lb[3]), .rd_data4(lb[4]),
        .rd_data5(lb[5]), .rd_data6(lb[6]), .rd_data7(lb[7]),
        .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]), .data_out4(dout[4]),
        .data_out5(dout[5]), .data_out6(dout[6]), .data_out7(dout[7]),
        .array_load_start(array_load_start), .row_cnt(row_cnt), .col_cnt(col_cnt),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] pat(input int lane, input int row, input int addr);
        return {8'(lane * 17), 8'(row), 8'(addr), 16'(lane * addr * 31 + row * 7 + 16'h5a00)};
    endfunction

    function automatic logic [7*WW-1:0] pack(input int row, input int addr);
        logic [7*WW-1:0] r;
        for (int n = 1; n <= 7; n++) r[(n-1)*WW +: WW] = pat(n, row, addr);
        return r;
    endfunction

    // Line buffer: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        for (int n = 1; n <= 7; n++)
            lb[n] <= rd_en ? pat(n, int'(rd_row), int'(rd_addr)) : WW'({$urandom(), $urandom()});
    end

    // Scoreboard monitor: reads push expected words, data_out pops them two cycles later.
    logic            en_d1 = 1'b0, en_d2 = 1'b0, en_d3 = 1'b0;
    int              k = 0;
    int              ea;
    logic [7*WW-1:0] sb [$];
    logic [7*WW-1:0] last_w = '0;
    logic [7*WW-1:0] cur;

    always @(negedge clk) begin
        if (rst) begin
            en_d1 = 1'b0; en_d2 = 1'b0; en_d3 = 1'b0;
            sb.delete();
            last_w = '0;
        end else begin
            if (frame_done === 1'b1) n_done++;
            if (en_d2) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL sb_underflow: data expected but queue empty at %0t", $time);
                end else begin
                    last_w = sb.pop_front();
                end
            end
            cur = {dout[7], dout[6], dout[5], dout[4], dout[3], dout[2], dout[1]};
            n_cmp++;
            if (cur !== last_w) begin
                n_fail++;
                $display("FAIL data_out at %0t: got lane1=%h required lane1=%h", $time, cur[WW-1:0], last_w[WW-1:0]);
            end
            n_cmp++;
            if (array_load_start !== (en_d2 && !en_d3)) begin
                n_fail++;
                $display("FAIL array_load_start at %0t: got %b required %b", $time, array_load_start, en_d2 && !en_d3);
            end
            if (rd_en === 1'b1) begin
                k  = en_d1 ? k + 1 : 0;
                ea = (exp_col * STRIDE + k) % (1 << AW);
                n_cmp++;
                if (rd_addr !== AW'(ea) || rd_row !== 4'(exp_row)) begin
                    n_fail++;
                    $display("FAIL rd_addr/rd_row at %0t: got %0d/%0d required %0d/%0d", $time, rd_addr, rd_row, ea, exp_row);
                end
                sb.push_back(pack(exp_row, ea));
            end
            en_d3 = en_d2; en_d2 = en_d1; en_d1 = rd_en;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_en !== 0 || rd_addr !== 0 || busy !== 0 || frame_done !== 0 || array_load_start !== 0
            || row_cnt !== 0 || col_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en=%b addr=%0d busy=%b done=%b ls=%b row=%0d col=%0d required all 0",
                     rd_en, rd_addr, busy, frame_done, array_load_start, row_cnt, col_cnt);
        end
        for (int n = 1; n <= 7; n++) begin
            n_cmp++;
            if (dout[n] !== '0) begin
                n_fail++;
                $display("FAIL reset_data lane %0d: got %h required 0", n, dout[n]);
            end
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got en=%b busy=%b required 0/0", rd_en, busy);
        end
    endtask

    task automatic fetch_tile(input int r, input int c, input bit spurious);
        int n;
        exp_row = r;
        exp_col = c;
        n = 0;
        while (rd_en !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_start_timeout tile(%0d,%0d): got rd_en=%b required 1", r, c, rd_en);
        end
        n = 0;
        while (rd_en === 1'b1 && n < 20) begin
            n_cmp++;
            if (row_cnt !== 4'(r) || col_cnt !== 5'(c)) begin
                n_fail++;
                $display("FAIL tile_pos: got %0d,%0d required %0d,%0d", row_cnt, col_cnt, r, c);
            end
            if (spurious && n == 5) begin tile_ack = 1'b1; frame_start = 1'b1; end
            @(posedge clk); #1;
            tile_ack = 1'b0; frame_start = 1'b0;
            n++;
        end
        n_cmp++;
        if (n != 13) begin
            n_fail++;
            $display("FAIL fetch_len tile(%0d,%0d): got %0d required 13", r, c, n);
        end
        for (int d = 0; d < 2; d++) begin
            if (spurious) begin tile_ack = 1'b1; frame_start = 1'b1; end
            @(posedge clk); #1;
            tile_ack = 1'b0; frame_start = 1'b0;
        end
        if (spurious) begin
            for (int w = 0; w < 3; w++) begin
                n_cmp++;
                if (rd_en !== 1'b0 || row_cnt !== 4'(r) || col_cnt !== 5'(c)) begin
                    n_fail++;
                    $display("FAIL spurious_ignored: got en=%b pos=%0d,%0d required 0 at %0d,%0d",
                             rd_en, row_cnt, col_cnt, r, c);
                end
                @(posedge clk); #1;
            end
        end
        tile_ack = 1'b1;
        @(posedge clk); #1;
        tile_ack = 1'b0;
    endtask

    task automatic test_frame(input bit with_spurious);
        int done0;
        int nr, nc;
        done0 = n_done;
        exp_row = 0; exp_col = 0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || row_cnt !== 0 || col_cnt !== 0) begin
            n_fail++;
            $display("FAIL frame_accept: got busy=%b en=%b pos=%0d,%0d required 1/1/0,0", busy, rd_en, row_cnt, col_cnt);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                fetch_tile(r, c, with_spurious && ((r == 0 && c == 1) || (r == 1 && c == 3)));
                nc = (c == COLS - 1) ? 0 : c + 1;
                nr = (c == COLS - 1) ? ((r == ROWS - 1) ? 0 : r + 1) : r;
                n_cmp++;
                if (r == ROWS - 1 && c == COLS - 1) begin
                    if (frame_done !== 1'b1 || busy !== 1'b0 || row_cnt !== 0 || col_cnt !== 0 || rd_en !== 1'b0) begin
                        n_fail++;
                        $display("FAIL frame_end: got done=%b busy=%b pos=%0d,%0d en=%b required 1/0/0,0/0",
                                 frame_done, busy, row_cnt, col_cnt, rd_en);
                    end
                end else if (frame_done !== 1'b0 || busy !== 1'b1 || row_cnt !== 4'(nr) || col_cnt !== 5'(nc)) begin
                    n_fail++;
                    $display("FAIL tile_advance: got done=%b busy=%b pos=%0d,%0d required 0/1/%0d,%0d",
                             frame_done, busy, row_cnt, col_cnt, nr, nc);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (frame_done !== 1'b0 || n_done != done0 + 1) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got level=%b count=%0d required 0/1", frame_done, n_done - done0);
        end
    endtask

    task automatic test_reset_mid_issue();
        int n;
        exp_row = 0; exp_col = 0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_en !== 0 || busy !== 0 || rd_addr !== 0 || dout[1] !== '0 || dout[7] !== '0 || array_load_start !== 0) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b busy=%b addr=%0d d1=%h required all 0", rd_en, busy, rd_addr, dout[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en !== 1'b0 || busy !== 1'b0) n++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL stays_idle_after_reset: got %0d active cycles required 0", n);
        end
    endtask

    task automatic test_back_to_back();
        test_frame(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame(1'b1);
        test_reset_mid_issue();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
